// File: rtl/piso_serializer.sv
// piso_serializer
//   Parallel-in/serial-out converter with valid/ready handshakes on both sides.
//   A one-word holding buffer (pbuf) lets the next word load on the same edge
//   that the last bit of the current word is consumed, giving gap-free output.
//
// Parameters
//   DATA_W     word width in bits (>= 2)
//   MSB_FIRST  1: bit DATA_W-1 leaves first; 0: bit 0 leaves first
//   IDLE_LEVEL serial_out level while serial_valid is low
//
// Ports
//   clk           rising-edge clock
//   pts_reset_n   synchronous active-low reset
//   abort         synchronous flush of active and pending words
//   in_valid      data_in holds a word
//   in_ready      holding buffer can accept a word
//   data_in       parallel word
//   serial_out    current serial bit
//   serial_valid  serial_out carries a data bit
//   serial_ready  downstream consumes the bit this cycle
//   serial_last   current bit is the last bit of its word
//   busy          shifting or word pending
module piso_serializer #(
  parameter int unsigned DATA_W     = 7,
  parameter bit          MSB_FIRST  = 1'b1,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic              clk,
  input  logic              pts_reset_n,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] data_in,
  output logic              serial_out,
  output logic              serial_valid,
  input  logic              serial_ready,
  output logic              serial_last,
  output logic              busy
);

  localparam int unsigned       CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(DATA_W - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t              state;
  logic [DATA_W-1:0]   sreg;
  logic [DATA_W-1:0]   pbuf;
  logic [CNT_W-1:0]    cnt;
  logic                pvalid;

  logic                active;
  logic                at_last;
  logic                bit_hs;
  logic                accept;
  logic                load;
  logic [DATA_W-1:0]   sreg_shifted;

  assign active   = (state == SHIFT);
  assign at_last  = (cnt == LAST_CNT);
  assign bit_hs   = active && serial_ready;
  assign in_ready = !pvalid && !abort;
  assign accept   = in_valid && in_ready;
  // A pending word moves into the shifter either when idle or on the very
  // edge that consumes the final bit, so consecutive words abut.
  assign load     = pvalid && (!active || (bit_hs && at_last));

  // Shift toward the output end, zero-filling the vacated position.
  always_comb begin
    sreg_shifted = '0;
    if (MSB_FIRST) begin
      sreg_shifted = {sreg[DATA_W-2:0], 1'b0};
    end else begin
      sreg_shifted = {1'b0, sreg[DATA_W-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!pts_reset_n) begin
      state  <= IDLE;
      sreg   <= '0;
      pbuf   <= '0;
      cnt    <= '0;
      pvalid <= 1'b0;
    end else if (abort) begin
      state  <= IDLE;
      cnt    <= '0;
      pvalid <= 1'b0;
    end else begin
      // accept needs pvalid=0 and load needs pvalid=1, so they never collide.
      if (accept) begin
        pbuf   <= data_in;
        pvalid <= 1'b1;
      end
      if (load) begin
        sreg   <= pbuf;
        cnt    <= '0;
        state  <= SHIFT;
        pvalid <= 1'b0;
      end else if (bit_hs) begin
        if (at_last) begin
          state <= IDLE;
          cnt   <= '0;
        end else begin
          cnt  <= cnt + 1'b1;
          sreg <= sreg_shifted;
        end
      end
    end
  end

  assign serial_valid = active;
  assign serial_last  = active && at_last;
  assign busy         = active || pvalid;
  assign serial_out   = !active ? IDLE_LEVEL
                                : (MSB_FIRST ? sreg[DATA_W-1] : sreg[0]);

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two instances (MSB-first/idle 0 and
// LSB-first/idle 1) share stimulus; a queue-based word model predicts both.
module tb_piso_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, abort, in_valid, serial_ready;
  logic [6:0] data_in;
  logic       rdy_m, out_m, val_m, last_m, busy_m;
  logic       rdy_l, out_l, val_l, last_l, busy_l;

  piso_serializer #(.DATA_W(7), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut_m (
    .clk(clk), .pts_reset_n(rst_n), .abort(abort), .in_valid(in_valid),
    .in_ready(rdy_m), .data_in(data_in), .serial_out(out_m),
    .serial_valid(val_m), .serial_ready(serial_ready),
    .serial_last(last_m), .busy(busy_m));

  piso_serializer #(.DATA_W(7), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_l (
    .clk(clk), .pts_reset_n(rst_n), .abort(abort), .in_valid(in_valid),
    .in_ready(rdy_l), .data_in(data_in), .serial_out(out_l),
    .serial_valid(val_l), .serial_ready(serial_ready),
    .serial_last(last_l), .busy(busy_l));

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the word in flight plus a queue of at most one pending word.
  logic       m_on = 1'b0;
  logic [6:0] m_cur = '0;
  int         m_pos = 0;
  logic [6:0] m_pend[$];

  always @(posedge clk) begin
    bit hs, acc;
    if (!rst_n) begin
      m_on = 1'b0; m_pos = 0; m_pend.delete();
    end else if (abort) begin
      m_on = 1'b0; m_pos = 0; m_pend.delete();
    end else begin
      hs  = m_on && serial_ready;
      acc = in_valid && (m_pend.size() == 0);
      if (hs) begin
        if (m_pos < 6) m_pos++;
        else m_on = 1'b0;
      end
      if (!m_on && m_pend.size() != 0) begin
        m_cur = m_pend.pop_front();
        m_pos = 0;
        m_on  = 1'b1;
      end
      if (acc) m_pend.push_back(data_in);
    end
  end

  // {in_ready, serial_valid, serial_out, serial_last, busy}
  function automatic logic [4:0] model_out(input bit msb);
    logic o;
    if (m_on) o = msb ? m_cur[6 - m_pos] : m_cur[m_pos];
    else      o = msb ? 1'b0 : 1'b1;
    return {(m_pend.size() == 0) && !abort, m_on, o,
            m_on && (m_pos == 6), m_on || (m_pend.size() != 0)};
  endfunction

  task automatic step(input logic r, input logic a, input logic iv,
                      input logic [6:0] d, input logic sr);
    @(negedge clk);
    rst_n = r; abort = a; in_valid = iv; data_in = d; serial_ready = sr;
    #1;
    chk("model_msb", {11'b0, rdy_m, val_m, out_m, last_m, busy_m}, {11'b0, model_out(1'b1)});
    chk("model_lsb", {11'b0, rdy_l, val_l, out_l, last_l, busy_l}, {11'b0, model_out(1'b0)});
  endtask

  typedef struct {
    logic       r, a, iv;
    logic [6:0] d;
    logic       sr;
    logic [5:0] exp; // {in_ready, valid, last, busy, out_msb, out_lsb}
  } vec_t;

  vec_t tbl[10];
  logic       vb[18];
  logic       ob[18];
  logic [13:0] bits14;
  logic [6:0]  word, got;
  logic [1:0]  frozen;
  int          run, nhs;

  initial begin
    tbl[0] = '{1'b1, 1'b0, 1'b1, 7'b1011001, 1'b1, 6'b1000_0_1};
    tbl[1] = '{1'b1, 1'b0, 1'b0, 7'b0000000, 1'b1, 6'b0001_0_1};
    tbl[2] = '{1'b1, 1'b0, 1'b0, 7'b0000000, 1'b1, 6'b1101_1_1};
    tbl[3] = '{1'b1, 1'b0, 1'b0, 7'b0000000, 1'b1, 6'b1101_0_0};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 7'b0000000, 1'b1, 6'b1101_1_0};
    tbl[5] = '{1'b1, 1'b0, 1'b0, 7'b0000000, 1'b1, 6'b1101_1_1};
    tbl[6] = '{1'b1, 1'b0, 1'b0, 7'b0000000, 1'b1, 6'b1101_0_1};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 7'b0000000, 1'b1, 6'b1101_0_0};
    tbl[8] = '{1'b1, 1'b0, 1'b0, 7'b0000000, 1'b1, 6'b1111_1_1};
    tbl[9] = '{1'b1, 1'b0, 1'b0, 7'b0000000, 1'b1, 6'b1000_0_1};

    rst_n = 1'b0; abort = 1'b0; in_valid = 1'b0; data_in = '0; serial_ready = 1'b1;
    repeat (2) @(posedge clk);

    // Single word 1011001 in both bit orders.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].r, tbl[i].a, tbl[i].iv, tbl[i].d, tbl[i].sr);
      chk($sformatf("table_row%0d", i),
          {10'b0, rdy_m, val_m, last_m, busy_m, out_m, out_l}, {10'b0, tbl[i].exp});
    end

    // Back-to-back 55 then 2A: 14 contiguous bits.
    for (int i = 0; i < 18; i++) begin
      step(1'b1, 1'b0, (i < 3), (i == 0) ? 7'h55 : 7'h2A, 1'b1);
      if (i == 1) chk("b2b_refused_while_full", {15'b0, rdy_m}, 16'd0);
      vb[i] = val_m; ob[i] = out_m;
    end
    run = 0; bits14 = '0;
    for (int i = 0; i < 18; i++) begin
      if (vb[i] && (run == 0 || vb[i-1])) begin
        bits14 = {bits14[12:0], ob[i]};
        run++;
      end
    end
    chk("b2b_contiguous_bits", 16'(run), 16'd14);
    chk("b2b_bit_stream", {2'b0, bits14}, {2'b0, 14'b10101010101010});

    // Backpressure at bit 3 for three cycles.
    word = 7'b1100101; got = '0; nhs = 0; frozen = '0;
    for (int i = 0; i < 14; i++) begin
      step(1'b1, 1'b0, (i == 0), word, !(i >= 5 && i <= 7));
      if (i == 5) begin
        frozen = {out_m, last_m};
        chk("stall_bit3_value", {15'b0, out_m}, {15'b0, word[3]});
      end
      if (i == 6 || i == 7 || i == 8) chk("stall_frozen", {14'b0, out_m, last_m}, {14'b0, frozen});
      if (val_m && serial_ready) begin got = {got[5:0], out_m}; nhs++; end
    end
    chk("stall_bit_count", 16'(nhs), 16'd7);
    chk("stall_word_intact", {9'b0, got}, {9'b0, word});

    // Abort mid-word with a word pending and another offered.
    for (int i = 0; i < 8; i++) begin
      step(1'b1, (i == 5), (i == 0 || i == 2 || i == 5),
           (i == 0) ? 7'h4B : ((i == 2) ? 7'h33 : 7'h1F), 1'b1);
      if (i == 5) chk("abort_refuses_word", {15'b0, rdy_m}, 16'd0);
      if (i == 6) chk("abort_flushed", {12'b0, val_m, busy_m, out_m, out_l}, 16'b0001);
      if (i == 7) chk("abort_nothing_accepted", {15'b0, busy_m}, 16'd0);
    end

    // Reset at bit 4, then a fresh word from bit 0.
    word = 7'b0110011; got = '0;
    for (int i = 0; i < 17; i++) begin
      step((i != 6), 1'b0, (i == 0 || i == 7), (i == 0) ? 7'h5A : word, 1'b1);
      if (i == 7) chk("reset_outputs",
                      {10'b0, rdy_m, val_m, last_m, busy_m, out_m, out_l}, 16'b1000_0_1);
      if (i >= 9 && i <= 15) got = {got[5:0], out_m};
    end
    chk("reset_new_word", {9'b0, got}, {9'b0, word});

    // Randomized traffic with occasional abort and reset.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(99) != 0), ($urandom_range(39) == 0),
           ($urandom_range(1) == 1), 7'($urandom), ($urandom_range(3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
